// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 DVP test-pattern source: FSM states,
// pattern mode codes and the RGB565 colour-bar palette.
package ov5640_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VSYNC   = 3'd1,
    S_V_BACK  = 3'd2,
    S_ACTIVE  = 3'd3,
    S_V_FRONT = 3'd4
  } dvp_state_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_SOLID   = 2'd2,
    PAT_CHECKER = 2'd3
  } pat_mode_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov5640_pat_gen.sv
// Pattern pixel generator: computes the RGB565 value of the next pixel and
// holds it in a register so it is ready the cycle its high byte goes out.
module ov5640_pat_gen
  import ov5640_pkg::*;
(
  input  logic        clk,
  input  logic        ld,
  input  pat_mode_e   mode,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [2:0]  bar_idx,
  input  logic        parity,
  input  logic [15:0] solid_rgb,
  output logic [15:0] pix_p0
);

  logic [7:0]  gray;
  logic [15:0] pix_c;
  logic        unused_ok;

  assign gray      = x[9:2];
  assign unused_ok = ^{x[10], x[1:0], y[10:6], y[4:0]};

  always_comb begin
    pix_c = RGB_BLACK;
    case (mode)
      PAT_BARS:    pix_c = bar_colour(bar_idx);
      PAT_RAMP:    pix_c = {gray[7:3], gray[7:2], gray[7:3]};
      PAT_SOLID:   pix_c = solid_rgb;
      PAT_CHECKER: pix_c = (x[5] ^ y[5] ^ parity) ? RGB_WHITE : RGB_BLACK;
      default:     pix_c = RGB_BLACK;
    endcase
  end

  // p0: pixel register, loaded on the edge that starts a pixel's high byte
  always_ff @(posedge clk) begin
    if (ld) pix_p0 <= pix_c;
  end

endmodule

// File: rtl/ov5640_dvp_gen.sv
// Synthesisable OV5640 DVP source: vsync/href/8-bit RGB565 byte stream with
// sensor-like frame timing and selectable test patterns.
module ov5640_dvp_gen
  import ov5640_pkg::*;
#(
  parameter int H_PIXEL = 640,
  parameter int V_PIXEL = 480,
  parameter int H_BLANK = 160,
  parameter int VSYNC_W = 4,
  parameter int V_BACK  = 16,
  parameter int V_FRONT = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        gen_en,
  input  logic [1:0]  pat_mode,
  input  logic [15:0] solid_rgb,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int          LINE_LEN = 2 * H_PIXEL + H_BLANK;
  localparam logic [11:0] H_LAST   = 12'(LINE_LEN - 1);
  localparam logic [11:0] H_ACT    = 12'(2 * H_PIXEL);
  localparam int          BAR_W    = H_PIXEL / 8;
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

  dvp_state_e  state_p0, state_nx;
  logic [11:0] hcnt_p0, hcnt_nx;
  logic [10:0] vcnt_p0, vcnt_nx;
  logic [10:0] lines_last;
  logic        line_end, latch_cfg;
  pat_mode_e   mode_q;
  logic [15:0] rgb_q;
  logic [2:0]  bar_idx_p0, bar_idx_nx;
  logic [10:0] bar_px_p0, bar_px_nx;
  logic [10:0] x_nx;
  logic        pix_ld;
  logic [15:0] pix_p0;
  logic        href_p0, frame_end_p0;

  function automatic logic [2:0] bar_sat_inc(input logic [2:0] idx);
    return (idx == 3'd7) ? idx : idx + 3'd1;
  endfunction

  assign line_end = (hcnt_p0 == H_LAST);

  always_comb begin
    lines_last = 11'd0;
    case (state_p0)
      S_VSYNC:   lines_last = 11'(VSYNC_W - 1);
      S_V_BACK:  lines_last = 11'(V_BACK - 1);
      S_ACTIVE:  lines_last = 11'(V_PIXEL - 1);
      S_V_FRONT: lines_last = 11'(V_FRONT - 1);
      default:   lines_last = 11'd0;
    endcase
  end

  // Every non-idle state is a whole number of equal-length lines
  always_comb begin
    state_nx  = state_p0;
    hcnt_nx   = hcnt_p0;
    vcnt_nx   = vcnt_p0;
    latch_cfg = 1'b0;
    if (state_p0 == S_IDLE) begin
      if (gen_en) begin
        state_nx  = S_VSYNC;
        hcnt_nx   = '0;
        vcnt_nx   = '0;
        latch_cfg = 1'b1;
      end
    end else if (!line_end) begin
      hcnt_nx = hcnt_p0 + 12'd1;
    end else begin
      hcnt_nx = '0;
      if (vcnt_p0 != lines_last) begin
        vcnt_nx = vcnt_p0 + 11'd1;
      end else begin
        vcnt_nx = '0;
        case (state_p0)
          S_VSYNC:  state_nx = S_V_BACK;
          S_V_BACK: state_nx = S_ACTIVE;
          S_ACTIVE: state_nx = S_V_FRONT;
          default: begin
            if (gen_en) begin
              state_nx  = S_VSYNC;
              latch_cfg = 1'b1;
            end else begin
              state_nx = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Pixel requests run on next-cycle counters so the pixel is registered in time
  assign x_nx   = hcnt_nx[11:1];
  assign pix_ld = (state_nx == S_ACTIVE) && !hcnt_nx[0] && (hcnt_nx < H_ACT);

  always_comb begin
    bar_idx_nx = bar_idx_p0;
    bar_px_nx  = bar_px_p0;
    if (x_nx == 11'd0) begin
      bar_idx_nx = '0;
      bar_px_nx  = '0;
    end else if (bar_px_p0 == BAR_LAST) begin
      bar_idx_nx = bar_sat_inc(bar_idx_p0);
      bar_px_nx  = '0;
    end else begin
      bar_px_nx = bar_px_p0 + 11'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_p0   <= S_IDLE;
      hcnt_p0    <= '0;
      vcnt_p0    <= '0;
      bar_idx_p0 <= '0;
      bar_px_p0  <= '0;
    end else begin
      state_p0 <= state_nx;
      hcnt_p0  <= hcnt_nx;
      vcnt_p0  <= vcnt_nx;
      if (pix_ld) begin
        bar_idx_p0 <= bar_idx_nx;
        bar_px_p0  <= bar_px_nx;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (latch_cfg) begin
      mode_q <= pat_mode_e'(pat_mode);
      rgb_q  <= solid_rgb;
    end
  end

  ov5640_pat_gen u_pat_gen (
    .clk       (sys_clk),
    .ld        (pix_ld),
    .mode      (mode_q),
    .x         (x_nx),
    .y         (vcnt_nx),
    .bar_idx   (bar_idx_nx),
    .parity    (frame_cnt[0]),
    .solid_rgb (rgb_q),
    .pix_p0    (pix_p0)
  );

  assign href_p0      = (state_p0 == S_ACTIVE) && (hcnt_p0 < H_ACT);
  assign frame_end_p0 = (state_p0 == S_ACTIVE) && (vcnt_p0 == 11'(V_PIXEL - 1))
                        && (hcnt_p0 == H_ACT);

  // p1: all DVP outputs registered together so vsync/href/data share one edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dvp_vsync   <= 1'b0;
      dvp_href    <= 1'b0;
      dvp_data    <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      dvp_vsync   <= (state_p0 == S_VSYNC);
      dvp_href    <= href_p0;
      dvp_data    <= href_p0 ? (hcnt_p0[0] ? pix_p0[7:0] : pix_p0[15:8]) : 8'h00;
      frame_start <= (state_p0 == S_VSYNC) && (hcnt_p0 == 12'd0) && (vcnt_p0 == 11'd0);
      frame_done  <= frame_end_p0;
      if (frame_end_p0) frame_cnt <= frame_cnt + 16'd1;
      busy        <= (state_p0 != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_gen.sv
// Directed bench for ov5640_dvp_gen using a reduced 16x4 frame (38-cycle lines).
module tb_ov5640_dvp_gen;

  localparam int L     = 38;
  localparam int FRAME = 266;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic [1:0]  pat_mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        dvp_vsync, dvp_href, frame_start, frame_done, busy;
  logic [7:0]  dvp_data;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int errors  = 0;
  int exp_fc  = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  bar_head [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0};

  always #5 sys_clk = ~sys_clk;

  ov5640_dvp_gen #(
    .H_PIXEL(16), .V_PIXEL(4), .H_BLANK(6), .VSYNC_W(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .gen_en      (gen_en),
    .pat_mode    (pat_mode),
    .solid_rgb   (solid_rgb),
    .dvp_vsync   (dvp_vsync),
    .dvp_href    (dvp_href),
    .dvp_data    (dvp_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    sys_rst_n = 1'b0;
    repeat (3) step();
    obs = {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy};
    vectors++;
    if (obs !== 13'h0) begin errors++; $display("FAIL reset_outputs got %h want 0000", obs); end
    vectors++;
    if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
    #2 sys_rst_n = 1'b1;
    repeat (3) step();
    vectors++;
    if ({busy, dvp_vsync} !== 2'b00) begin errors++; $display("FAIL idle_hold got %b want 00", {busy, dvp_vsync}); end
  endtask

  task automatic test_timing();
    logic [12:0] obs, want;
    logic        hr, vs, fs, fd;
    logic [7:0]  db;
    int t, ln, h;
    pat_mode = 2'd2; solid_rgb = 16'hABCD; gen_en = 1'b1;
    step();
    vectors++;
    if ({dvp_vsync, busy} !== 2'b00) begin errors++; $display("FAIL timing_sample_edge got %b want 00", {dvp_vsync, busy}); end
    for (int c = 1; c <= FRAME; c++) begin
      step();
      t = c - 1; ln = t / L; h = t % L;
      vs = (ln == 0);
      hr = (ln >= 2) && (ln <= 5) && (h < 32);
      db = hr ? (((h % 2) == 1) ? 8'hCD : 8'hAB) : 8'h00;
      fs = (t == 0);
      fd = (ln == 5) && (h == 32);
      want = {vs, hr, db, fs, fd, 1'b1};
      obs  = {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy};
      vectors++;
      if (obs !== want) begin errors++; $display("FAIL timing c=%0d got %h want %h", c, obs, want); end
      if (c == FRAME - 1) gen_en = 1'b0;
    end
    step();
    obs = {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy};
    vectors++;
    if (obs !== 13'h0) begin errors++; $display("FAIL timing_idle got %h want 0000", obs); end
    exp_fc = 1;
    vectors++;
    if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL timing_frame_cnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_bars();
    bit ok;
    logic [15:0] col;
    logic [8:0]  want;
    pat_mode = 2'd0; gen_en = 1'b1;
    wait_fs(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL bars_start got timeout want frame_start"); end
    repeat (75) step();
    for (int b = 0; b < 32; b++) begin
      step();
      col  = bars[b / 4];
      want = {1'b1, ((b % 2) == 1) ? col[7:0] : col[15:8]};
      vectors++;
      if ({dvp_href, dvp_data} !== want) begin
        errors++; $display("FAIL bars byte=%0d got %h want %h", b, {dvp_href, dvp_data}, want);
      end
    end
    gen_en = 1'b0;
    wait_idle(ok);
    exp_fc++;
    vectors++;
    if (!ok || frame_cnt !== 16'(exp_fc)) begin
      errors++; $display("FAIL bars_end got idle=%0d cnt=%0d want idle=1 cnt=%0d", ok, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_mode_latch();
    bit ok;
    int rel;
    logic [7:0] want;
    pat_mode = 2'd2; solid_rgb = 16'h1234; gen_en = 1'b1;
    wait_fs(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL latch_start got timeout want frame_start"); end
    rel = 1;
    while (rel < 154) begin
      step(); rel++;
      if (rel == 100) begin pat_mode = 2'd0; solid_rgb = 16'hFFFF; end
      if (rel == 153 || rel == 154) begin
        want = (rel == 153) ? 8'h12 : 8'h34;
        vectors++;
        if (dvp_data !== want) begin errors++; $display("FAIL latch_solid rel=%0d got %h want %h", rel, dvp_data, want); end
      end
    end
    wait_fs(ok);
    gen_en = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL latch_next got timeout want frame_start"); end
    rel = 1;
    while (rel < 82) begin
      step(); rel++;
      if (rel >= 77) begin
        vectors++;
        if (dvp_data !== bar_head[rel - 77]) begin
          errors++; $display("FAIL latch_bars rel=%0d got %h want %h", rel, dvp_data, bar_head[rel - 77]);
        end
      end
    end
    wait_idle(ok);
    exp_fc += 2;
    vectors++;
    if (!ok || frame_cnt !== 16'(exp_fc)) begin
      errors++; $display("FAIL latch_end got idle=%0d cnt=%0d want idle=1 cnt=%0d", ok, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_stop_mid();
    bit ok, prev_hr;
    int rel, rises, fs_n, fd_n;
    pat_mode = 2'd2; solid_rgb = 16'h5A3C; gen_en = 1'b1;
    wait_fs(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL stop_start got timeout want frame_start"); end
    rel = 1; rises = 0; fs_n = 0; fd_n = 0; prev_hr = 1'b0;
    while (busy && rel < 600) begin
      step(); rel++;
      if (dvp_href && !prev_hr) rises++;
      prev_hr = dvp_href;
      fs_n += int'(frame_start);
      fd_n += int'(frame_done);
      if (rel == 160) gen_en = 1'b0;
    end
    vectors++;
    if (rel !== 267) begin errors++; $display("FAIL stop_busy_fall got rel=%0d want 267", rel); end
    vectors++;
    if (rises !== 4) begin errors++; $display("FAIL stop_lines got %0d want 4", rises); end
    vectors++;
    if (fs_n !== 0 || fd_n !== 1) begin
      errors++; $display("FAIL stop_pulses got fs=%0d fd=%0d want fs=0 fd=1", fs_n, fd_n);
    end
    exp_fc++;
    vectors++;
    if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL stop_frame_cnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rel, last_fs, nfs, f, r;
    logic [7:0] want;
    pat_mode = 2'd3; gen_en = 1'b1;
    wait_fs(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL b2b_start got timeout want frame_start"); end
    rel = 1; last_fs = 1; nfs = 1;
    while (rel < 3 * FRAME) begin
      step(); rel++;
      f = (rel - 1) / FRAME;
      r = (rel - 1) % FRAME + 1;
      if (frame_start) begin
        vectors++;
        if (rel - last_fs != FRAME) begin
          errors++; $display("FAIL b2b_spacing got %0d want %0d", rel - last_fs, FRAME);
        end
        last_fs = rel; nfs++;
      end
      if (r == 77 || r == 78) begin
        want = (((exp_fc + f) % 2) == 1) ? 8'hFF : 8'h00;
        vectors++;
        if (dvp_data !== want) begin errors++; $display("FAIL b2b_checker f=%0d r=%0d got %h want %h", f, r, dvp_data, want); end
      end
      if (rel == 2 * FRAME + 50) gen_en = 1'b0;
    end
    wait_idle(ok);
    vectors++;
    if (!ok || nfs !== 3) begin errors++; $display("FAIL b2b_frames got idle=%0d starts=%0d want idle=1 starts=3", ok, nfs); end
    exp_fc += 3;
    vectors++;
    if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [12:0] obs;
    pat_mode = 2'd2; solid_rgb = 16'hABCD; gen_en = 1'b1;
    wait_fs(ok);
    repeat (79) step();
    vectors++;
    if (!ok || dvp_href !== 1'b1) begin errors++; $display("FAIL rstmid_pre got href=%b want 1", dvp_href); end
    #2 sys_rst_n = 1'b0;
    #1;
    obs = {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy};
    vectors++;
    if (obs !== 13'h0 || frame_cnt !== 16'h0) begin
      errors++; $display("FAIL rstmid_async got %h cnt=%h want 0000 cnt=0000", obs, frame_cnt);
    end
    gen_en = 1'b0;
    #2 sys_rst_n = 1'b1;
    repeat (2) step();
    obs = {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy};
    vectors++;
    if (obs !== 13'h0) begin errors++; $display("FAIL rstmid_idle got %h want 0000", obs); end
    gen_en = 1'b1;
    step();
    vectors++;
    if (dvp_vsync !== 1'b0) begin errors++; $display("FAIL rstmid_early got vsync=%b want 0", dvp_vsync); end
    step();
    gen_en = 1'b0;
    vectors++;
    if ({dvp_vsync, frame_start, frame_cnt} !== {2'b11, 16'h0}) begin
      errors++; $display("FAIL rstmid_restart got vs=%b fs=%b cnt=%h want vs=1 fs=1 cnt=0000",
                         dvp_vsync, frame_start, frame_cnt);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL rstmid_end got timeout want idle"); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_mode_latch();
    test_stop_mid();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
